// File: rtl/washer_pkg.sv
// Shared definitions for the wash machine controller.
//   - 4-bit state encodings
//   - load-size codes, as sent on tmr_load
//   - timer flag counts: the count at which each timer flag goes high
//   - helpers that classify states and step through the phase sequence
package washer_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FILL   = 4'd1,
    S_WASH   = 4'd2,
    S_DRAIN1 = 4'd3,
    S_RFILL  = 4'd4,
    S_RINSE  = 4'd5,
    S_DRAIN2 = 4'd6,
    S_SPIN   = 4'd7,
    S_DONE   = 4'd8,
    S_PAUSE  = 4'd9,
    S_FAULT  = 4'd10
  } state_t;

  localparam logic [1:0] LOAD_SMALL   = 2'b00;
  localparam logic [1:0] LOAD_MEDIUM  = 2'b01;
  localparam logic [1:0] LOAD_LARGE   = 2'b10;
  localparam logic [1:0] LOAD_ILLEGAL = 2'b11;

  // Timer count at which each flag is raised. A phase lasts its count + 2
  // cycles: one entry cycle, then counts 0..n.
  localparam int CNT_D   = 1;
  localparam int CNT_F   = 2;
  localparam int CNT_W_S = 2;
  localparam int CNT_W_M = 4;
  localparam int CNT_W_L = 8;
  localparam int CNT_R   = 4;
  localparam int CNT_S   = 7;

  // Timed phases are FILL through SPIN; each one waits on a timer flag.
  function automatic logic is_timed(state_t s);
    return (s >= S_FILL) && (s <= S_SPIN);
  endfunction

  function automatic state_t next_phase(state_t s);
    case (s)
      S_FILL:   return S_WASH;
      S_WASH:   return S_DRAIN1;
      S_DRAIN1: return S_RFILL;
      S_RFILL:  return S_RINSE;
      S_RINSE:  return S_DRAIN2;
      S_DRAIN2: return S_SPIN;
      S_SPIN:   return S_DONE;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/washer_phase_wdog.sv
// Per-phase watchdog counter.
//   clk     : system clock
//   R       : synchronous active-high reset
//   clr     : clear the count. It is asserted on the edge that enters a phase,
//             so the count reads 0 during the entry cycle.
//   timeout : high while the count equals PHASE_MAX-1
module washer_phase_wdog #(
  parameter int PHASE_MAX = 12
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(PHASE_MAX - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (R || clr) begin
      cnt <= 4'd0;
    end else if (cnt != 4'hF) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/washer_controller.sv
// Sequencing FSM for the wash machine. It consumes the washer timer flags and
// drives the timer restart/load inputs, the actuators, the door lock and the
// status outputs.
//   clk, R              : clock and synchronous active-high reset
//   start, lid, load    : user controls (lid=1 means open; load 11 is illegal)
//   Td/Tf/Tr/Ts/Tw      : timer flags, each high for one count value
//   tmr_R, tmr_load     : timer restart and latched load code
//   fill_valve, drain_valve, agitate, spin, lock : actuator drives
//   done, reject        : one-cycle pulses
//   fault               : watchdog fault level
//   state               : current state code
// Every output is registered. Output values are decoded from the next state,
// so they change on the same edge as state.
module washer_controller
  import washer_pkg::*;
#(
  parameter int PHASE_MAX = 12
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic       lid,
  input  logic [1:0] load,
  input  logic       Td,
  input  logic       Tf,
  input  logic       Tr,
  input  logic       Ts,
  input  logic       Tw,
  output logic       tmr_R,
  output logic [1:0] tmr_load,
  output logic       fill_valve,
  output logic       drain_valve,
  output logic       agitate,
  output logic       spin,
  output logic       lock,
  output logic       done,
  output logic       fault,
  output logic       reject,
  output logic [3:0] state
);

  state_t st, nxt, saved;
  logic   flag, enter, accept, refuse, wd_timeout;

  assign state = st;

  // enter is the restart for both the timer and the watchdog.
  washer_phase_wdog #(.PHASE_MAX(PHASE_MAX)) u_wdog (
    .clk     (clk),
    .R       (R),
    .clr     (enter),
    .timeout (wd_timeout)
  );

  always_comb begin
    nxt    = st;
    flag   = 1'b0;
    accept = 1'b0;
    refuse = 1'b0;

    case (st)
      S_FILL, S_RFILL:   flag = Tf;
      S_WASH:            flag = Tw;
      S_DRAIN1, S_DRAIN2: flag = Td;
      S_RINSE:           flag = Tr;
      S_SPIN:            flag = Ts;
      default:           flag = 1'b0;
    endcase

    case (st)
      S_IDLE: begin
        if (start && !lid) begin
          accept = (load != LOAD_ILLEGAL);
          refuse = (load == LOAD_ILLEGAL);
        end
        if (accept) nxt = S_FILL;
      end
      S_FILL, S_WASH, S_DRAIN1, S_RFILL, S_RINSE, S_DRAIN2, S_SPIN: begin
        // tmr_R is high only during a phase's entry cycle, and the timer
        // count is stale then, so the flag is not trusted in that cycle.
        if (lid)                nxt = S_PAUSE;
        else if (flag && !tmr_R) nxt = next_phase(st);
        else if (wd_timeout)    nxt = S_FAULT;
      end
      S_DONE:  nxt = S_IDLE;
      S_PAUSE: if (!lid) nxt = saved;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase

    // Restart the timer in every non-timed state and on entry to any phase.
    // A phase resumed from PAUSE is a fresh entry.
    enter = !is_timed(nxt) || (nxt != st);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      st          <= S_IDLE;
      saved       <= S_IDLE;
      tmr_R       <= 1'b1;
      tmr_load    <= LOAD_SMALL;
      fill_valve  <= 1'b0;
      drain_valve <= 1'b0;
      agitate     <= 1'b0;
      spin        <= 1'b0;
      lock        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      reject      <= 1'b0;
    end else begin
      st <= nxt;
      if (nxt == S_PAUSE && st != S_PAUSE) saved <= st;
      tmr_R <= enter;
      if (accept) tmr_load <= load;
      fill_valve  <= (nxt == S_FILL) || (nxt == S_RFILL);
      drain_valve <= (nxt == S_DRAIN1) || (nxt == S_DRAIN2) ||
                     (nxt == S_SPIN) || (nxt == S_FAULT);
      agitate     <= (nxt == S_WASH) || (nxt == S_RINSE);
      spin        <= (nxt == S_SPIN);
      lock        <= is_timed(nxt);
      done        <= (nxt == S_DONE);
      fault       <= (nxt == S_FAULT);
      reject      <= refuse;
    end
  end

endmodule

// File: tb/tb_washer_controller.sv
// Directed bench for washer_controller with an attached washer timer model.
// The expected output vector for each cycle is pushed to a scoreboard queue
// when the stimulus is applied. One entry is popped and compared at every
// falling edge.
module tb_washer_controller;

  logic       clk = 1'b0;
  logic       R, start, lid;
  logic [1:0] load;
  logic       Td, Tf, Tr, Ts, Tw;
  logic       tmr_R;
  logic [1:0] tmr_load;
  logic       fill_valve, drain_valve, agitate, spin, lock, done, fault, reject;
  logic [3:0] state;

  washer_controller #(.PHASE_MAX(12)) dut (
    .clk         (clk),
    .R           (R),
    .start       (start),
    .lid         (lid),
    .load        (load),
    .Td          (Td),
    .Tf          (Tf),
    .Tr          (Tr),
    .Ts          (Ts),
    .Tw          (Tw),
    .tmr_R       (tmr_R),
    .tmr_load    (tmr_load),
    .fill_valve  (fill_valve),
    .drain_valve (drain_valve),
    .agitate     (agitate),
    .spin        (spin),
    .lock        (lock),
    .done        (done),
    .fault       (fault),
    .reject      (reject),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Timer model. The count clears while tmr_R is high and otherwise counts
  // up. Each flag is high at exactly one count value.
  logic [7:0] tcnt = 8'd0;
  logic       tw_kill = 1'b0;
  logic [7:0] wcnt;

  always @(posedge clk) begin
    if (tmr_R === 1'b1)     tcnt <= 8'd0;
    else if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
  end

  assign wcnt = (tmr_load == 2'b00) ? 8'd2 : (tmr_load == 2'b01) ? 8'd4 : 8'd8;
  assign Td = (tcnt == 8'd1);
  assign Tf = (tcnt == 8'd2);
  assign Tr = (tcnt == 8'd4);
  assign Ts = (tcnt == 8'd7);
  assign Tw = !tw_kill && (tcnt == wcnt);

  typedef struct {
    string       tag;
    logic [14:0] v;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          pcyc = 0;
  string       tname = "init";
  logic [1:0]  cur_tl = 2'b00;

  // Vector layout: {state, tmr_R, tmr_load, fill, drain, agitate, spin, lock,
  // done, fault, reject}. The actuator bits follow from the state code.
  function automatic logic [14:0] exp_vec(input int s, input logic trst,
                                          input logic [1:0] tl, input logic rej);
    logic f, d, a, sp, lk, dn, ft;
    logic [3:0] sc;
    sc = 4'(s);
    f  = (s == 1) || (s == 4);
    d  = (s == 3) || (s == 6) || (s == 7) || (s == 10);
    a  = (s == 2) || (s == 5);
    sp = (s == 7);
    lk = (s >= 1) && (s <= 7);
    dn = (s == 8);
    ft = (s == 10);
    return {sc, trst, tl, f, d, a, sp, lk, dn, ft, rej};
  endfunction

  task automatic push_st(input int s, input logic trst, input logic rej);
    exp_t e;
    pcyc++;
    e.tag = $sformatf("%s_c%0d", tname, pcyc);
    e.v   = exp_vec(s, trst, cur_tl, rej);
    sbq.push_back(e);
  endtask

  task automatic push_phase(input int s, input int len);
    for (int i = 0; i < len; i++) push_st(s, (i == 0), 1'b0);
  endtask

  task automatic push_run(input logic [1:0] ld);
    int w;
    w = (ld == 2'b00) ? 4 : (ld == 2'b01) ? 6 : 10;
    push_phase(1, 4);
    push_phase(2, w);
    push_phase(3, 3);
    push_phase(4, 4);
    push_phase(5, 6);
    push_phase(6, 3);
    push_phase(7, 9);
    push_st(8, 1'b1, 1'b0);
    push_st(0, 1'b1, 1'b0);
  endtask

  task automatic check_one();
    logic [14:0] obs;
    exp_t        e;
    obs = {state, tmr_R, tmr_load, fill_valve, drain_valve, agitate, spin,
           lock, done, fault, reject};
    n_cmp++;
    assert (sbq.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty_%s: observed %h with no expected entry", tname, obs);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_one();
    end
  endtask

  task automatic drain_q();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      tick(1);
      guard++;
    end
  endtask

  task automatic full_cycle(input logic [1:0] ld);
    tname = $sformatf("run%0d", ld);
    pcyc = 0;
    cur_tl = ld;
    start = 1'b1;
    load = ld;
    push_run(ld);
    tick(1);
    start = 1'b0;
    drain_q();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    R = 1'b1; start = 1'b0; lid = 1'b0; load = 2'b00;

    // Reset state.
    tname = "reset"; pcyc = 0;
    push_st(0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_one();
    R = 1'b0;
    push_st(0, 1'b1, 1'b0);
    tick(1);

    // Full cycles for each legal load.
    full_cycle(2'b00);
    full_cycle(2'b01);
    full_cycle(2'b10);

    // An illegal load is refused with a single reject pulse.
    tname = "reject"; pcyc = 0;
    start = 1'b1; load = 2'b11;
    push_st(0, 1'b1, 1'b1);
    tick(1);
    start = 1'b0;
    push_st(0, 1'b1, 1'b0);
    tick(1);

    // A start with the lid open is ignored.
    tname = "lidstart"; pcyc = 0;
    start = 1'b1; lid = 1'b1; load = 2'b00;
    push_st(0, 1'b1, 1'b0);
    tick(1);
    start = 1'b0; lid = 1'b0;
    push_st(0, 1'b1, 1'b0);
    tick(1);

    // Lid opened at cycle 18 (RINSE) for 3 cycles.
    tname = "pause"; pcyc = 0; cur_tl = 2'b00;
    start = 1'b1; load = 2'b00;
    push_phase(1, 4); push_phase(2, 4); push_phase(3, 3); push_phase(4, 4);
    push_phase(5, 3);
    push_st(9, 1'b1, 1'b0); push_st(9, 1'b1, 1'b0); push_st(9, 1'b1, 1'b0);
    push_phase(5, 6); push_phase(6, 3); push_phase(7, 9);
    push_st(8, 1'b1, 1'b0); push_st(0, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(17);
    lid = 1'b1;
    tick(3);
    lid = 1'b0;
    drain_q();

    // Watchdog: Tw never arrives, so WASH times out into FAULT at cycle 17.
    tname = "wdog"; pcyc = 0; cur_tl = 2'b00;
    tw_kill = 1'b1;
    start = 1'b1; load = 2'b00;
    push_phase(1, 4); push_phase(2, 12);
    for (int i = 0; i < 4; i++) push_st(10, 1'b1, 1'b0);
    tick(1);
    start = 1'b0;
    tick(16);
    start = 1'b1;
    tick(1);
    start = 1'b0; lid = 1'b1;
    tick(2);
    lid = 1'b0;
    R = 1'b1;
    tname = "wdog_rst";
    push_st(0, 1'b1, 1'b0);
    tick(1);
    R = 1'b0; tw_kill = 1'b0;
    push_st(0, 1'b1, 1'b0);
    tick(1);

    // Reset during SPIN (load 01, SPIN entered at cycle 27).
    tname = "spinrst"; pcyc = 0; cur_tl = 2'b01;
    start = 1'b1; load = 2'b01;
    push_phase(1, 4); push_phase(2, 6); push_phase(3, 3); push_phase(4, 4);
    push_phase(5, 6); push_phase(6, 3); push_phase(7, 1);
    tick(1);
    start = 1'b0;
    tick(26);
    R = 1'b1;
    cur_tl = 2'b00;
    push_st(0, 1'b1, 1'b0);
    tick(1);
    R = 1'b0;
    push_st(0, 1'b1, 1'b0);
    tick(1);

    // A new start after the reset runs normally.
    full_cycle(2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_controller.md
Name: washer_controller

Overview:
- Sequencing FSM for the wash machine controller; the consumer side of the washer timer interface.
- Drives the timer's restart (R) and load-select inputs and reacts to its one-hot-per-count flags Td/Tf/Tr/Ts/Tw.
- Drives the fill valve, drain valve, agitate motor, spin motor, door lock and status outputs.
- Adds lid-pause, rejection of illegal loads and a per-phase watchdog.

Parameters:
- PHASE_MAX, 12, max cycles allowed in any timed phase before entering FAULT (legal 11..15).

Ports:
- clk  in  1  system clock
- R  in  1  synchronous active-high reset
- start  in  1  level; begin a cycle when sampled high in IDLE
- lid  in  1  1 = lid open
- load  in  2  load size: 00 small, 01 medium, 10 large, 11 illegal
- Td  in  1  timer drain flag
- Tf  in  1  timer fill flag
- Tr  in  1  timer rinse flag
- Ts  in  1  timer spin flag
- Tw  in  1  timer wash flag
- tmr_R  out  1  restart to timer (timer R)
- tmr_load  out  2  load code latched at start, to timer load
- fill_valve  out  1  fill valve drive
- drain_valve  out  1  drain valve drive
- agitate  out  1  agitate motor drive
- spin  out  1  spin motor drive
- lock  out  1  door lock
- done  out  1  one-cycle completion pulse
- fault  out  1  level, watchdog fault
- reject  out  1  one-cycle pulse, start refused
- state  out  4  current state code

Behaviour:
- Clock, reset and registers
  - One clock domain, clk. R is synchronous and active-high.
  - All outputs are registered.
  - R has priority over every other input.
- Reset values
  - Reset state is IDLE.
  - tmr_R=1, tmr_load=00.
  - All actuator, lock, done, fault and reject outputs are 0.
  - state = IDLE code.
- Phase sequence and exit flags
  - FILL: Tf
  - WASH: Tw
  - DRAIN1: Td
  - RFILL: Tf
  - RINSE: Tr
  - DRAIN2: Td
  - SPIN: Ts
  - DONE: one cycle, then IDLE.
  - Additional states: IDLE, PAUSE, FAULT.
- Actuator outputs per state
  - FILL/RFILL: fill_valve=1.
  - WASH/RINSE: agitate=1.
  - DRAIN1/DRAIN2: drain_valve=1.
  - SPIN: spin=1 and drain_valve=1.
  - FAULT: drain_valve=1, fault=1.
  - lock=1 in FILL..SPIN; lock=0 in all other states.
- Timer handshake
  - tmr_R=1 continuously in IDLE, PAUSE, DONE and FAULT.
  - tmr_R=1 for exactly the first cycle of every timed phase (the entry cycle).
  - Exit flags are ignored during the entry cycle, because the timer count is stale.
  - From the entry cycle k, the timer count is 0 at k+1 and n at k+1+n.
  - The phase exits on the edge ending the cycle in which its flag is high, so phase length = flag count + 2.
  - Resulting phase lengths: FILL 4, DRAIN 3, RINSE 6, SPIN 9; WASH 4/6/10 for load 00/01/10.
- Start and reject (IDLE)
  - IDLE with start=1, lid=0 and load!=11 → FILL next cycle; tmr_load latches load.
  - start with load=11 → stay in IDLE; reject=1 for one cycle.
  - start with lid=1 → ignored; no reject.
  - start outside IDLE is ignored.
- Lid pause
  - lid=1 in any timed phase → PAUSE next cycle; the phase is saved.
  - Lid has priority over an exit flag in the same cycle.
  - PAUSE: all actuators off, lock=0.
  - lid=0 in PAUSE → return to the saved phase and re-enter it from its start (entry cycle, tmr_R=1, watchdog cleared).
  - Lid is ignored in DONE and FAULT.
- Watchdog
  - A 4-bit phase counter is cleared on each phase entry and increments every cycle in the phase.
  - If the counter reaches PHASE_MAX-1 with no exit flag, the next state is FAULT.
- FAULT
  - FAULT is terminal; it is exited only by R.
- tmr_load
  - Holds its value until the next accepted start.

Decomposition:
- Package washer_pkg holds:
  - the state encodings (4-bit): IDLE=0, FILL=1, WASH=2, DRAIN1=3, RFILL=4, RINSE=5, DRAIN2=6, SPIN=7, DONE=8, PAUSE=9, FAULT=10;
  - the load codes;
  - the timer flag counts: D=1, F=2, W=2/4/8, R=4, S=7.
- Sub-module washer_phase_wdog: phase counter with clear and timeout output.

Test Plan:
- Full cycle, load 00: R, then start at cycle 0 with timer model attached → FILL 1-4, WASH 5-8, DRAIN1 9-11, RFILL 12-15, RINSE 16-21, DRAIN2 22-24, SPIN 25-33; done=1 at cycle 34 only; lock=1 over cycles 1-33.
- Load 01 and load 10 full cycles → done at cycles 36 and 40 respectively; tmr_load is 01 and 10 throughout.
- start with load=11 → reject=1 for one cycle, state stays IDLE, tmr_R=1. start with lid=1 → no state change and no reject.
- Lid pause: lid=1 at cycle 18 (RINSE) for 3 cycles → PAUSE cycles 19-21 with actuators and lock 0; RINSE re-entered at 22 with tmr_R=1; done at cycle 40.
- Watchdog: Tw forced to 0, load 00 → FAULT at cycle 17; fault=1 and drain_valve=1 until R; start is ignored while in FAULT.
- R asserted at cycle 27 (SPIN) → next cycle IDLE, all outputs at reset values, tmr_R=1; a new start works normally.
